// File: rtl/truth_table_scanner_pkg.sv
// truth_table_scanner_pkg: shared state encoding and sizes for the truth table scanner
package truth_table_scanner_pkg;
  localparam int MINTERMS = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;
  localparam int TMR_W = 4;
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_FINISH} state_t;
endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// truth_table_scanner_settle_timer: loadable down-counter pacing the settle wait
module truth_table_scanner_settle_timer
  import truth_table_scanner_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [TMR_W-1:0] value,
  output logic             expired
);
  logic [TMR_W-1:0] cnt;
  // load when a minterm is driven, count down while settling
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= value;
    else if (dec) cnt <= cnt - 1'b1;
  assign expired = cnt <= TMR_W'(1);
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks all 8 minterms of an external function and captures its truth table
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE = 1
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       letra,
  output logic [3:0]       sel_out,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic             s,
  output logic             busy,
  output logic             done,
  output logic [7:0]       mask,
  output logic [CNT_W-1:0] count
);
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic expired, accept, live, load, dec, capture, fin, last;
  assign last = idx == IDX_W'(MINTERMS - 1);
  assign {x, y, z} = idx;
  truth_table_scanner_settle_timer settle_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .dec     (dec),
    .value   (TMR_W'(SETTLE)),
    .expired (expired)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_nxt;
  // next state: start only counts in IDLE, abort wins everywhere else
  always_comb begin
    state_nxt = state;
    if (state == S_IDLE) state_nxt = start ? S_DRIVE : S_IDLE;
    else if (abort) state_nxt = S_IDLE;
    else
      case (state)
        S_DRIVE:  state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
        S_SETTLE: state_nxt = expired ? S_SAMPLE : S_SETTLE;
        S_SAMPLE: state_nxt = last ? S_FINISH : S_DRIVE;
        default:  state_nxt = S_IDLE;
      endcase
  end
  // per-state strobes; an abort suppresses every action of the aborted state
  always_comb begin
    accept  = state == S_IDLE && start;
    live    = state != S_IDLE && !abort;
    load    = live && state == S_DRIVE;
    dec     = live && state == S_SETTLE;
    capture = live && state == S_SAMPLE;
    fin     = live && state == S_FINISH;
  end
  // datapath: latch selector, capture samples, flag completion
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx     <= '0;
      mask    <= '0;
      count   <= '0;
      sel_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= fin;
      if (accept) begin
        idx     <= '0;
        mask    <= '0;
        count   <= '0;
        sel_out <= letra;
        busy    <= 1'b1;
      end
      if (fin || (state != S_IDLE && abort)) busy <= 1'b0;
      if (capture) begin
        mask[idx] <= s;
        count     <= count + CNT_W'(s);
        idx       <= last ? idx : idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: two scanners (SETTLE=1 and SETTLE=0) against a cycle-level behavioural model
module tb_truth_table_scanner;
  logic clk = 0, reset = 1, start = 0, abort = 0;
  logic [3:0] letra = 0;
  logic s1 = 0, s0 = 0;
  int fn = 0;
  logic [3:0] sel1, sel0, cnt1, cnt0;
  logic [7:0] mask1, mask0;
  logic x1, y1, z1, x0, y0, z0, busy1, busy0, done1, done0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  truth_table_scanner #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .letra(letra),
    .sel_out(sel1), .x(x1), .y(y1), .z(z1), .s(s1),
    .busy(busy1), .done(done1), .mask(mask1), .count(cnt1)
  );
  truth_table_scanner #(.SETTLE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .letra(letra),
    .sel_out(sel0), .x(x0), .y(y0), .z(z0), .s(s0),
    .busy(busy0), .done(done0), .mask(mask0), .count(cnt0)
  );

  function automatic logic f(input int sel, input int k);
    logic [2:0] m;
    m = 3'(k);
    case (sel)
      0: return (~m[2] & m[1]) | (m[2] & m[1]);
      1: return (~m[2] & ~m[1] & ~m[0]) | (~m[2] & m[1] & m[0]) | (m[2] & ~m[1] & m[0]) | (m[2] & m[1] & m[0]);
      2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: a scan is 8 minterms of P=SETTLE+2 cycles each, counted from the accept edge
  bit m_act[2];
  int m_t[2];
  logic [7:0] m_mask[2];
  logic [3:0] m_cnt[2], m_sel[2];
  logic m_busy[2], m_done[2];

  function automatic int per(input int d);
    return d == 1 ? 3 : 2;
  endfunction

  always @(posedge clk or posedge reset)
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_act[d] = 0; m_t[d] = 0; m_mask[d] = 0; m_cnt[d] = 0;
        m_sel[d] = 0; m_busy[d] = 0; m_done[d] = 0;
      end else begin
        m_done[d] = 0;
        if (!m_act[d]) begin
          if (start) begin
            m_act[d] = 1; m_t[d] = 0; m_mask[d] = 0; m_cnt[d] = 0;
            m_sel[d] = letra; m_busy[d] = 1;
          end
        end else if (abort) begin
          m_act[d] = 0; m_busy[d] = 0;
        end else begin
          m_t[d]++;
          if (m_t[d] % per(d) == 0 && m_t[d] <= 8 * per(d)) begin
            m_mask[d][m_t[d] / per(d) - 1] = f(fn, m_t[d] / per(d) - 1);
            m_cnt[d] += 4'(f(fn, m_t[d] / per(d) - 1));
          end
          if (m_t[d] == 8 * per(d) + 1) begin
            m_done[d] = 1; m_busy[d] = 0; m_act[d] = 0;
          end
        end
      end
    end

  // drive s: the function value in the sampling cycle, random noise otherwise
  always @(negedge clk) begin
    s1 = (m_act[1] && (m_t[1] + 1) % 3 == 0 && m_t[1] < 24) ? f(fn, m_t[1] / 3) : 1'($urandom);
    s0 = (m_act[0] && (m_t[0] + 1) % 2 == 0 && m_t[0] < 16) ? f(fn, m_t[0] / 2) : 1'($urandom);
  end

  // compare both DUTs against the model every cycle
  always @(negedge clk) begin
    chk("busy1", 32'(busy1), 32'(m_busy[1]));
    chk("done1", 32'(done1), 32'(m_done[1]));
    chk("mask1", 32'(mask1), 32'(m_mask[1]));
    chk("count1", 32'(cnt1), 32'(m_cnt[1]));
    chk("sel1", 32'(sel1), 32'(m_sel[1]));
    chk("busy0", 32'(busy0), 32'(m_busy[0]));
    chk("done0", 32'(done0), 32'(m_done[0]));
    chk("mask0", 32'(mask0), 32'(m_mask[0]));
    chk("count0", 32'(cnt0), 32'(m_cnt[0]));
    chk("sel0", 32'(sel0), 32'(m_sel[0]));
    if (m_act[1]) chk("xyz1", 32'({x1, y1, z1}), 32'(m_t[1] / 3 > 7 ? 7 : m_t[1] / 3));
    if (m_act[0]) chk("xyz0", 32'({x0, y0, z0}), 32'(m_t[0] / 2 > 7 ? 7 : m_t[0] / 2));
  end

  task automatic scan(input logic [3:0] l, input int fsel, input bit with_abort, input bit extra,
                      output int lat1, output int lat0, output int nd1);
    @(negedge clk);
    fn = fsel; letra = l; start = 1; abort = with_abort;
    @(negedge clk);
    start = 0; abort = 0;
    lat1 = -1; lat0 = -1; nd1 = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (done1) begin
        nd1++;
        if (lat1 < 0) lat1 = e;
      end
      if (done0 && lat0 < 0) lat0 = e;
      start = extra && e >= 5 && e < 8;
      if (start) letra = 4'hf;
    end
  endtask

  int l1, l0, nd;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_mask", 32'(mask1), 0);
    chk("rst_count", 32'(cnt1), 0);
    chk("rst_sel", 32'(sel1), 0);
    chk("rst_xyz", 32'({x1, y1, z1}), 0);
    chk("rst_done", 32'(done1), 0);
    reset = 0;

    scan(4'ha, 0, 0, 0, l1, l0, nd);
    chk("lat_s1", 32'(l1), 25);
    chk("lat_s0", 32'(l0), 17);
    chk("y_mask", 32'(mask1), 32'h cc);
    chk("y_count", 32'(cnt1), 4);
    chk("y_sel", 32'(sel1), 32'h a);
    chk("y_mask0", 32'(mask0), 32'h cc);

    scan(4'hb, 1, 0, 0, l1, l0, nd);
    chk("f1_mask", 32'(mask1), 32'h a9);
    chk("f1_count", 32'(cnt1), 4);

    scan(4'h3, 2, 1, 0, l1, l0, nd);
    chk("ones_mask0", 32'(mask0), 32'h ff);
    chk("ones_count0", 32'(cnt0), 8);
    chk("ones_lat0", 32'(l0), 17);
    chk("ones_sel", 32'(sel1), 32'h 3);

    scan(4'h4, 3, 0, 0, l1, l0, nd);
    chk("zeros_mask0", 32'(mask0), 0);
    chk("zeros_count0", 32'(cnt0), 0);
    chk("zeros_lat0", 32'(l0), 17);

    @(negedge clk);
    fn = 2; letra = 4'h6; start = 1;
    @(negedge clk);
    start = 0;
    repeat (14) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_done", 32'(done1), 0);
    chk("abort_hi", 32'(mask1[7:5]), 0);
    chk("abort_mask", 32'(mask1), 32'h 0f);
    chk("abort_count", 32'(cnt1), 4);
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done1) nd++;
    end
    chk("abort_nodone", 32'(nd), 0);

    scan(4'h5, 0, 0, 1, l1, l0, nd);
    chk("busy_start_sel", 32'(sel1), 32'h 5);
    chk("busy_start_lat", 32'(l1), 25);
    chk("busy_start_ndone", 32'(nd), 1);
    chk("busy_start_mask", 32'(mask1), 32'h cc);

    @(negedge clk);
    fn = 0; letra = 4'h9; start = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    chk("pre_rst_mask", 32'(mask1), 32'h 04);
    #2 reset = 1;
    #1;
    chk("arst_busy", 32'(busy1), 0);
    chk("arst_mask", 32'(mask1), 0);
    chk("arst_count", 32'(cnt1), 0);
    chk("arst_sel", 32'(sel1), 0);
    chk("arst_xyz", 32'({x1, y1, z1}), 0);
    chk("arst_busy0", 32'(busy0), 0);
    @(negedge clk);
    reset = 0;
    scan(4'h7, 1, 0, 0, l1, l0, nd);
    chk("post_rst_mask", 32'(mask1), 32'h a9);
    chk("post_rst_lat", 32'(l1), 25);
    chk("post_rst_ndone", 32'(nd), 1);
    chk("post_rst_sel", 32'(sel1), 32'h 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
